// File: rtl/meas_processor.sv
// Display-path value selector: live pass-through, frozen hold, or boxcar average of 2^AVG_LOG2 samples.
// Latency: one clk from the qualifying adc_valid sample to disp_data/disp_valid.
// Backpressure: none; accepts one sample per cycle, back-to-back strobes included.
module meas_processor #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                meas_enable,
    input  logic                hold_enable,
    input  logic                average_enable,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    output logic [DATA_W-1:0]   disp_data,
    output logic                disp_valid,
    output logic [AVG_LOG2-1:0] avg_count,
    output logic                avg_busy
);

    // Accumulator is wide enough that a full window of full-scale samples cannot overflow.
    localparam int ACC_W = DATA_W + AVG_LOG2;

    localparam logic [AVG_LOG2-1:0] CNT_ONE  = AVG_LOG2'(1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_MEAS = 2'd1,
        MODE_HOLD = 2'd2,
        MODE_AVG  = 2'd3
    } mode_t;

    mode_t               mode;
    logic [ACC_W-1:0]    acc;
    logic                prev_avg;

    logic [ACC_W-1:0]    sample_ext;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_nxt;
    logic [AVG_LOG2-1:0] cnt_nxt;
    logic [DATA_W-1:0]   disp_data_nxt;
    logic                disp_valid_nxt;

    assign sample_ext = {{AVG_LOG2{1'b0}}, adc_data};
    assign acc_sum    = acc + sample_ext;

    // Mode decode with fixed priority MEAS > HOLD > AVERAGE; nothing enabled is IDLE.
    always_comb begin
        mode = MODE_IDLE;
        if (meas_enable)         mode = MODE_MEAS;
        else if (hold_enable)    mode = MODE_HOLD;
        else if (average_enable) mode = MODE_AVG;
    end

    // Next-state for display value, accumulator and sample count.
    always_comb begin
        disp_data_nxt  = disp_data;
        disp_valid_nxt = 1'b0;
        acc_nxt        = '0;
        cnt_nxt        = '0;
        case (mode)
            MODE_MEAS: begin
                if (adc_valid) begin
                    disp_data_nxt  = adc_data;
                    disp_valid_nxt = 1'b1;
                end
            end
            MODE_AVG: begin
                if (!prev_avg) begin
                    // Fresh window on entry: any stale partial sum is dropped.
                    acc_nxt = adc_valid ? sample_ext : '0;
                    cnt_nxt = adc_valid ? CNT_ONE : '0;
                end else if (adc_valid) begin
                    if (avg_count == CNT_LAST) begin
                        // Window completes with this sample: truncating divide by the window length.
                        disp_data_nxt  = acc_sum[ACC_W-1:AVG_LOG2];
                        disp_valid_nxt = 1'b1;
                    end else begin
                        acc_nxt = acc_sum;
                        cnt_nxt = avg_count + CNT_ONE;
                    end
                end else begin
                    acc_nxt = acc;
                    cnt_nxt = avg_count;
                end
            end
            default: begin
                // HOLD and IDLE: display frozen, samples discarded, window cleared.
            end
        endcase
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data  <= '0;
            disp_valid <= 1'b0;
            acc        <= '0;
            avg_count  <= '0;
            prev_avg   <= 1'b0;
        end else begin
            disp_data  <= disp_data_nxt;
            disp_valid <= disp_valid_nxt;
            acc        <= acc_nxt;
            avg_count  <= cnt_nxt;
            prev_avg   <= (mode == MODE_AVG);
        end
    end

    assign avg_busy = (avg_count != '0);

endmodule
